if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/pc_reg.sv | 52 +++++
 rtl/if_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, opcodes, FSM encoding and helpers for the fetch stage
//
// Purpose: common definitions imported by if_stage and pc_reg.
//   NOP_INSTR        : all-zero instruction loaded into flushed IF/ID slots
//   OP_*             : main-decoder opcode constants (instr[31:26])
//   DEFAULT_RESET_PC : default byte address loaded into PC on reset
//   if_state_e       : fetch FSM states (BOOT, RUN, PEND)
//   npc_sel_e        : next-PC mux select
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD  = 2'd0,
    NPC_INC   = 2'd1,
    NPC_REDIR = 2'd2,
    NPC_PEND  = 2'd3
  } npc_sel_e;

  // Redirect targets are byte addresses; fetch is always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with next-PC mux
//
// Purpose: holds the fetch PC and selects the next PC.
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset, loads RESET_PC
//   sel_i          : next-PC select (hold, increment, redirect, pending)
//   redirect_pc_i  : live redirect target (byte address)
//   pend_pc_i      : latched pending redirect target (byte address)
//   pc_o           : current PC
//   pc_plus4_o     : PC + 4, wrapping modulo 2^32
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  npc_sel_e    sel_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] pend_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // 32-bit add drops the carry, so FFFF_FFFC + 4 wraps to 0.
  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  always_comb begin
    pc_d = pc_q;
    unique case (sel_i)
      NPC_HOLD:  pc_d = pc_q;
      NPC_INC:   pc_d = pc_plus4_o;
      NPC_REDIR: pc_d = word_align(redirect_pc_i);
      NPC_PEND:  pc_d = word_align(pend_pc_i);
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and deferred redirect
//
// Purpose: drives instruction memory from the PC, captures the fetched word
// into the IF/ID register, and handles stalls and branch/jump redirects.
// Optional feature macro: DELAY_SLOT_EN (when defined, the instruction fetched
// in the redirect cycle is kept as a delay slot instead of being flushed).
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   stall         : hazard hold of PC and IF/ID
//   redirect      : taken beq / j resolved in ID
//   redirect_pc   : redirect target byte address
//   imem_addr     : current PC to combinational-read instruction memory
//   imem_rdata    : instruction word at imem_addr
//   instr_out     : IF/ID instruction
//   op_out        : instr_out[31:26]
//   pc_plus4_out  : IF/ID fetch PC + 4
//   valid_out     : IF/ID holds a real instruction
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [5:0]  op_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  if_state_e   state_q;
  logic [31:0] pend_q;
  logic [31:0] instr_q;
  logic [31:0] pp4_q;
  logic        valid_q;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  npc_sel_e    npc_sel;
  logic        flush;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .sel_i         (npc_sel),
    .redirect_pc_i (redirect_pc),
    .pend_pc_i     (pend_q),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4)
  );

  // A live redirect beats a pending one when both are present in PEND.
  always_comb begin
    npc_sel = NPC_HOLD;
    unique case (state_q)
      ST_RUN:  if (!stall) npc_sel = redirect ? NPC_REDIR : NPC_INC;
      ST_PEND: if (!stall) npc_sel = redirect ? NPC_REDIR : NPC_PEND;
      default: npc_sel = NPC_HOLD;
    endcase
  end

  always_comb begin
`ifdef DELAY_SLOT_EN
    flush = 1'b0;
`else
    flush = (npc_sel == NPC_REDIR) || (npc_sel == NPC_PEND);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pend_q  <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      pp4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN, ST_PEND: begin
          if (stall) begin
            if (redirect) begin
              pend_q  <= redirect_pc;
              state_q <= ST_PEND;
            end
          end else begin
            instr_q <= flush ? NOP_INSTR : imem_rdata;
            valid_q <= !flush;
            pp4_q   <= pc_plus4;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign imem_addr    = pc;
  assign instr_out    = instr_q;
  assign op_out       = instr_q[31:26];
  assign pc_plus4_out = pp4_q;
  assign valid_out    = valid_q;

endmodule
